// File: rtl/lc3_fetch_prefetch.sv
// Instruction prefetch unit: issues sequential reads under a credit rule and
// buffers {instr, pc} pairs in a small queue, with branch redirect and flush.
module lc3_fetch_prefetch #(
  parameter int              AW       = 16,
  parameter int              DW       = 16,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = 16'h3000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_taken,
  input  logic [AW-1:0]            taddr,
  output logic                     imem_rd,
  output logic [AW-1:0]            imem_addr,
  input  logic [DW-1:0]            imem_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_instr,
  output logic [AW-1:0]            out_pc,
  output logic [AW-1:0]            out_npc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] PC_ONE   = AW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW:0]   DEPTH_X  = (CW+1)'(DEPTH);

  logic [AW-1:0] fetch_pc_r;
  logic          inflight_r;
  logic [AW-1:0] infl_pc_r;
  logic [DW-1:0] instr_q_r [DEPTH];
  logic [AW-1:0] pc_q_r    [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          pop_s;
  logic          push_s;
  logic          rd_s;
  logic [CW:0]   occ_s;

  // Issue credit: queued entries plus the outstanding read must fit in the queue.
  always_comb begin
    occ_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    pop_s  = (count_r != CNT_ZERO) && out_ready;
    push_s = inflight_r && !br_taken && !rst;
    if (rst || br_taken) begin
      rd_s = 1'b0;
    end else if (occ_s < DEPTH_X) begin
      rd_s = 1'b1;
    end else if ((occ_s == DEPTH_X) && pop_s) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Head presentation; fields read as zero whenever the queue is empty.
  always_comb begin
    out_valid = (count_r != CNT_ZERO);
    count     = count_r;
    imem_rd   = rd_s;
    imem_addr = fetch_pc_r;
    if (count_r != CNT_ZERO) begin
      out_instr = instr_q_r[head_r];
      out_pc    = pc_q_r[head_r];
      out_npc   = pc_q_r[head_r] + PC_ONE;
    end else begin
      out_instr = {DW{1'b0}};
      out_pc    = {AW{1'b0}};
      out_npc   = {AW{1'b0}};
    end
  end

  // Fetch PC and the single outstanding-read tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      inflight_r <= 1'b0;
      infl_pc_r  <= {AW{1'b0}};
    end else begin
      inflight_r <= rd_s;
      if (br_taken) begin
        fetch_pc_r <= taddr;
      end else if (rd_s) begin
        fetch_pc_r <= fetch_pc_r + PC_ONE;
        infl_pc_r  <= fetch_pc_r;
      end
    end
  end

  // Queue pointers and occupancy; a redirect or reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst || br_taken) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; push already excludes reset and redirect cycles.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_q_r[tail_r] <= imem_dout;
      pc_q_r[tail_r]    <= infl_pc_r;
    end
  end

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Directed bench for lc3_fetch_prefetch: memory returns addr ^ 16'hA5A5 one
// cycle after each read; each step checks hand-computed expectations.
module tb_lc3_fetch_prefetch;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [15:0] taddr;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_dout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_npc;
  logic [2:0]  count;

  int n_cmp;
  int n_err;
  logic [15:0] e;

  lc3_fetch_prefetch dut (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (br_taken),
    .taddr     (taddr),
    .imem_rd   (imem_rd),
    .imem_addr (imem_addr),
    .imem_dout (imem_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_npc   (out_npc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial imem_dout = 16'h0000;
  always @(posedge clk) begin
    if (imem_rd) imem_dout <= imem_addr ^ 16'hA5A5;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; br_taken = 1'b0; taddr = 16'h0000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk1 ("rst_rd",    imem_rd,   1'b0);
    chk16("rst_addr",  imem_addr, 16'h3000);
    chk16("rst_count", 16'(count), 16'd0);
    chk1 ("rst_valid", out_valid, 1'b0);
    chk16("rst_pc",    out_pc,    16'h0000);
    chk16("rst_instr", out_instr, 16'h0000);
    chk16("rst_npc",   out_npc,   16'h0000);

    // release: first read at RESET_PC, head appears two cycles later
    rst = 1'b0; #1;
    chk1 ("rel_rd",   imem_rd,   1'b1);
    chk16("rel_addr", imem_addr, 16'h3000);
    cyc();
    chk1 ("lat_valid0", out_valid, 1'b0);
    chk16("lat_addr1",  imem_addr, 16'h3001);
    for (int k = 0; k < 6; k++) begin
      cyc();
      e = 16'h3000 + 16'(k);
      chk1 ("stream_valid", out_valid, 1'b1);
      chk16("stream_pc",    out_pc,    e);
      chk16("stream_instr", out_instr, e ^ 16'hA5A5);
      chk16("stream_npc",   out_npc,   e + 16'h0001);
      chk16("stream_count", 16'(count), 16'd1);
    end

    // mid-operation reset with consumer stalled
    rst = 1'b1; out_ready = 1'b0;
    cyc();
    chk16("mrst_count", 16'(count), 16'd0);
    chk1 ("mrst_valid", out_valid, 1'b0);
    rst = 1'b0; #1;
    chk1 ("stall_c0_rd",   imem_rd,   1'b1);
    chk16("stall_c0_addr", imem_addr, 16'h3000);
    cyc();
    chk16("mrst_noinfl", 16'(count), 16'd0);
    repeat (3) cyc();
    chk1 ("stall_c4_rd",    imem_rd,   1'b0);
    chk16("stall_c4_count", 16'(count), 16'd3);
    repeat (5) cyc();
    chk16("stall_c9_count", 16'(count), 16'd4);
    chk1 ("stall_c9_rd",    imem_rd,   1'b0);
    chk16("stall_c9_pc",    out_pc,    16'h3000);
    chk16("stall_c9_instr", out_instr, 16'h95A5);
    cyc();
    out_ready = 1'b1; #1;
    chk1 ("drain_rd",   imem_rd,   1'b1);
    chk16("drain_addr", imem_addr, 16'h3004);
    chk16("drain_pc0",  out_pc,    16'h3000);
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk1 ("drain_valid", out_valid, 1'b1);
      chk16("drain_pc",    out_pc,    16'h3000 + 16'(k));
    end
    chk16("pre_br_count", 16'(count), 16'd3);

    // redirect with queue at 3 and a read outstanding
    cyc();
    br_taken = 1'b1; taddr = 16'h4000; #1;
    chk1 ("br_rd0",    imem_rd,   1'b0);
    chk16("br_pop_pc", out_pc,    16'h3005);
    chk16("br_count",  16'(count), 16'd3);
    cyc();
    br_taken = 1'b0; #1;
    chk16("br1_count", 16'(count), 16'd0);
    chk1 ("br1_valid", out_valid, 1'b0);
    chk1 ("br1_rd",    imem_rd,   1'b1);
    chk16("br1_addr",  imem_addr, 16'h4000);
    cyc();
    chk1 ("br2_valid", out_valid, 1'b0);
    chk16("br2_addr",  imem_addr, 16'h4001);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk1 ("br_tgt_valid", out_valid, 1'b1);
      chk16("br_tgt_pc",    out_pc,    16'h4000 + 16'(k));
    end

    // back-to-back redirects: only the last target is fetched
    cyc();
    br_taken = 1'b1; taddr = 16'h5000; #1;
    chk1("bb1_rd", imem_rd, 1'b0);
    cyc();
    taddr = 16'h6000; #1;
    chk1 ("bb2_rd",    imem_rd, 1'b0);
    chk16("bb2_count", 16'(count), 16'd0);
    cyc();
    br_taken = 1'b0; #1;
    chk1 ("bb3_rd",    imem_rd,   1'b1);
    chk16("bb3_addr",  imem_addr, 16'h6000);
    chk1 ("bb3_valid", out_valid, 1'b0);
    cyc();
    chk1("bb4_valid", out_valid, 1'b0);
    cyc();
    chk16("bb5_pc",    out_pc,    16'h6000);
    chk16("bb5_instr", out_instr, 16'hC5A5);
    cyc();
    chk16("bb6_pc", out_pc, 16'h6001);

    // wrap: redirect to FFFE right after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0; br_taken = 1'b1; taddr = 16'hFFFE; #1;
    chk1("wrap_rd0", imem_rd, 1'b0);
    cyc();
    br_taken = 1'b0; #1;
    chk16("wrap_addr0", imem_addr, 16'hFFFE);
    cyc();
    chk16("wrap_addr1", imem_addr, 16'hFFFF);
    cyc();
    chk16("wrap_addr2", imem_addr, 16'h0000);
    chk16("wrap_pc0",   out_pc,    16'hFFFE);
    chk16("wrap_ins0",  out_instr, 16'h5A5B);
    chk16("wrap_npc0",  out_npc,   16'hFFFF);
    cyc();
    chk16("wrap_pc1",   out_pc,    16'hFFFF);
    chk16("wrap_npc1",  out_npc,   16'h0000);
    chk16("wrap_ins1",  out_instr, 16'h5A5A);
    cyc();
    chk16("wrap_pc2",   out_pc,    16'h0000);
    chk16("wrap_npc2",  out_npc,   16'h0001);
    chk16("wrap_ins2",  out_instr, 16'hA5A5);

    // single-cycle reset while the queue is full
    out_ready = 1'b0;
    repeat (8) cyc();
    chk16("full_count", 16'(count), 16'd4);
    rst = 1'b1; #1;
    chk1("frst_rd", imem_rd, 1'b0);
    cyc();
    rst = 1'b0; #1;
    chk16("frst_count", 16'(count), 16'd0);
    chk1 ("frst_valid", out_valid, 1'b0);
    chk1 ("frst_rd1",   imem_rd,   1'b1);
    chk16("frst_addr",  imem_addr, 16'h3000);
    cyc();
    chk16("frst_c1_count", 16'(count), 16'd0);
    cyc();
    chk16("frst_c2_count", 16'(count), 16'd1);
    chk16("frst_c2_pc",    out_pc,    16'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
